// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier, signed/unsigned, fixed latency
//
// Computes the full 2*WIDTH-bit product of two WIDTH-bit operands, one Booth
// iteration per clock, WIDTH+1 iterations per operation.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset (deassertion synchronised)
//   multInit     start request, sampled while not busy
//   signed_mode  1 = two's complement operands, 0 = unsigned (sampled with multInit)
//   value_A_Mc   multiplicand (sampled with multInit)
//   value_B_Mp   multiplier (sampled with multInit)
//   busy         high while an operation is running
//   done         one-cycle pulse when hi/low take a new result
//   hi           product bits [2*WIDTH-1:WIDTH]
//   low          product bits [WIDTH-1:0]
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             multInit,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] value_A_Mc,
  input  logic [WIDTH-1:0] value_B_Mp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] low
);

  // One extra bit lets both signed and unsigned operands be treated as signed,
  // so the same Booth recoding covers both modes and the product is exact.
  localparam int EW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  logic          rst_sync;
  logic [EW-1:0] m_reg;
  logic [EW-1:0] q_reg;
  logic [EW-1:0] acc;
  logic          q_1;
  logic [CW-1:0] count;

  logic          start;
  logic          last_iter;
  logic [EW-1:0] sum;
  logic [EW-1:0] acc_next;
  logic [EW-1:0] q_next;

  // Reset asserts asynchronously but releases on a clock edge: starts are
  // held off until the edge after this flop has seen reset_n high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 1'b0;
    end else begin
      rst_sync <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start      = rst_sync && multInit && (state != RUN);
    last_iter  = (state == RUN) && (count == LAST_ITER);
    busy       = (state == RUN);
    done       = (state == DONE);
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (last_iter) state_next = DONE;
      DONE: state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One Booth step: recode {Q[0], q_1}, add/subtract M, then arithmetic
  // shift {Acc, Q, q_1} right by one.
  always_comb begin
    sum = acc;
    unique case ({q_reg[0], q_1})
      2'b10:   sum = acc - m_reg;
      2'b01:   sum = acc + m_reg;
      default: sum = acc;
    endcase
    acc_next = {sum[EW-1], sum[EW-1:1]};
    q_next   = {sum[0], q_reg[EW-1:1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_reg <= '0;
      q_reg <= '0;
      acc   <= '0;
      q_1   <= 1'b0;
      count <= '0;
      hi    <= '0;
      low   <= '0;
    end else if (start) begin
      m_reg <= signed_mode ? {value_A_Mc[WIDTH-1], value_A_Mc} : {1'b0, value_A_Mc};
      q_reg <= signed_mode ? {value_B_Mp[WIDTH-1], value_B_Mp} : {1'b0, value_B_Mp};
      acc   <= '0;
      q_1   <= 1'b0;
      count <= '0;
    end else if (state == RUN) begin
      acc   <= acc_next;
      q_reg <= q_next;
      q_1   <= q_reg[0];
      count <= count + CW'(1);
      // {Acc, Q} holds 2*WIDTH+2 bits; the top two are pure sign bits.
      if (last_iter) begin
        hi  <= {acc_next[WIDTH-2:0], q_next[WIDTH]};
        low <= q_next[WIDTH-1:0];
      end
    end
  end

endmodule
